// File: rtl/complex_sub_pipe.sv
// complex_sub_pipe: registered z-minus-root stage emitting (z - zero[i]) and (z - pole[i]) for every root.
// Roots live in shadow/active banks; commits land on frame boundaries. Define SATURATE_EN to clamp instead of wrap.
module complex_sub_pipe #(
  parameter int W      = 16,
  parameter int N_ZERO = 4,
  parameter int N_POLE = 4,
  parameter int IDX_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic                cfg_sel,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [2*W-1:0]      cfg_data,
  input  logic                cfg_commit,
  output logic                commit_pending,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_x,
  input  logic [W-1:0]        in_y,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [N_ZERO*W-1:0] out_zero_re,
  output logic [N_ZERO*W-1:0] out_zero_im,
  output logic [N_POLE*W-1:0] out_pole_re,
  output logic [N_POLE*W-1:0] out_pole_im,
  output logic                out_sat,
  output logic                dbg_state
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} commit_state_e;

  commit_state_e state, state_d;
  logic [2*W-1:0] shadow_zero   [N_ZERO];
  logic [2*W-1:0] shadow_zero_d [N_ZERO];
  logic [2*W-1:0] active_zero   [N_ZERO];
  logic [2*W-1:0] shadow_pole   [N_POLE];
  logic [2*W-1:0] shadow_pole_d [N_POLE];
  logic [2*W-1:0] active_pole   [N_POLE];
  logic           in_frame;
  logic           accept;
  logic           do_copy;
  logic [N_ZERO*W-1:0] zre_d, zim_d;
  logic [N_POLE*W-1:0] pre_d, pim_d;

`ifdef SATURATE_EN
  localparam int RW = W + 1;
  logic sat_d;
  logic sat_q;

  // Returns {clamped, value}: difference taken at W+1 bits, then clamped to the signed W-bit range.
  function automatic logic [W:0] sub_root(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] wide;
    wide = {a[W-1], a} - {b[W-1], b};
    if (wide[W] != wide[W-1]) return {1'b1, wide[W], {(W-1){~wide[W]}}};
    return {1'b0, wide[W-1:0]};
  endfunction
`else
  localparam int RW = W;

  function automatic logic [W-1:0] sub_root(input logic [W-1:0] a, input logic [W-1:0] b);
    return a - b;
  endfunction
`endif

  logic [RW-1:0] r_re, r_im;

  // Valid/ready: a beat moves on an edge where valid && ready. The single output register
  // refills whenever it is empty or draining, so in_ready is combinational from out_ready,
  // and out_* hold stable while out_valid && !out_ready.
  assign in_ready       = !out_valid || out_ready;
  assign accept         = in_valid && in_ready;
  assign commit_pending = (state == PEND);
  assign dbg_state      = state;

  // Shadow next-value: a same-cycle write is merged before any copy to the active bank.
  always_comb begin
    for (int i = 0; i < N_ZERO; i++) begin
      shadow_zero_d[i] = shadow_zero[i];
      if (cfg_we && !cfg_sel && i == int'(cfg_idx)) shadow_zero_d[i] = cfg_data;
    end
    for (int i = 0; i < N_POLE; i++) begin
      shadow_pole_d[i] = shadow_pole[i];
      if (cfg_we && cfg_sel && i == int'(cfg_idx)) shadow_pole_d[i] = cfg_data;
    end
  end

  always_comb begin
    state_d = state;
    do_copy = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_commit) begin
          if (!in_frame && !accept) do_copy = 1'b1;
          else                      state_d = PEND;
        end
      end
      PEND: begin
        // The closing beat itself still sees the old roots; the copy lands on the same edge.
        if (accept && in_last) begin
          do_copy = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    zre_d = '0;
    zim_d = '0;
    pre_d = '0;
    pim_d = '0;
    r_re  = '0;
    r_im  = '0;
`ifdef SATURATE_EN
    sat_d = 1'b0;
`endif
    for (int i = 0; i < N_ZERO; i++) begin
      r_re = sub_root(in_x, active_zero[i][2*W-1:W]);
      r_im = sub_root(in_y, active_zero[i][W-1:0]);
      zre_d[i*W +: W] = r_re[W-1:0];
      zim_d[i*W +: W] = r_im[W-1:0];
`ifdef SATURATE_EN
      sat_d = sat_d | r_re[W] | r_im[W];
`endif
    end
    for (int i = 0; i < N_POLE; i++) begin
      r_re = sub_root(in_x, active_pole[i][2*W-1:W]);
      r_im = sub_root(in_y, active_pole[i][W-1:0]);
      pre_d[i*W +: W] = r_re[W-1:0];
      pim_d[i*W +: W] = r_im[W-1:0];
`ifdef SATURATE_EN
      sat_d = sat_d | r_re[W] | r_im[W];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_frame    <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_zero_re <= '0;
      out_zero_im <= '0;
      out_pole_re <= '0;
      out_pole_im <= '0;
      for (int i = 0; i < N_ZERO; i++) begin
        shadow_zero[i] <= '0;
        active_zero[i] <= '0;
      end
      for (int i = 0; i < N_POLE; i++) begin
        shadow_pole[i] <= '0;
        active_pole[i] <= '0;
      end
    end else begin
      state <= state_d;
      for (int i = 0; i < N_ZERO; i++) begin
        shadow_zero[i] <= shadow_zero_d[i];
        if (do_copy) active_zero[i] <= shadow_zero_d[i];
      end
      for (int i = 0; i < N_POLE; i++) begin
        shadow_pole[i] <= shadow_pole_d[i];
        if (do_copy) active_pole[i] <= shadow_pole_d[i];
      end
      if (accept) begin
        in_frame    <= !in_last;
        out_valid   <= 1'b1;
        out_last    <= in_last;
        out_zero_re <= zre_d;
        out_zero_im <= zim_d;
        out_pole_re <= pre_d;
        out_pole_im <= pim_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SATURATE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sat_q <= 1'b0;
    else if (accept) sat_q <= sat_d;
  end
  assign out_sat = sat_q;
`else
  assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_complex_sub_pipe.sv
// Directed bench for complex_sub_pipe (W=16, 4 zeros, 4 poles) plus a 3-zero instance for the
// out-of-range index case. Honours SATURATE_EN for the clamp expectations.
module tb_complex_sub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic        cfg_sel = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_commit = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_x = '0;
  logic [15:0] in_y = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        commit_pending, in_ready, out_valid, out_last, out_sat, dbg_state;
  logic [63:0] out_zero_re, out_zero_im, out_pole_re, out_pole_im;

  logic        commit_pending3, in_ready3, out_valid3, out_last3, out_sat3, dbg_state3;
  logic [47:0] out_zero_re3, out_zero_im3;
  logic [63:0] out_pole_re3, out_pole_im3;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  complex_sub_pipe dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit), .commit_pending(commit_pending),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_zero_re(out_zero_re), .out_zero_im(out_zero_im),
    .out_pole_re(out_pole_re), .out_pole_im(out_pole_im),
    .out_sat(out_sat), .dbg_state(dbg_state)
  );

  complex_sub_pipe #(.N_ZERO(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit), .commit_pending(commit_pending3),
    .in_valid(in_valid), .in_ready(in_ready3), .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .out_valid(out_valid3), .out_ready(out_ready), .out_last(out_last3),
    .out_zero_re(out_zero_re3), .out_zero_im(out_zero_im3),
    .out_pole_re(out_pole_re3), .out_pole_im(out_pole_im3),
    .out_sat(out_sat3), .dbg_state(dbg_state3)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] x, input logic [15:0] y, input logic last);
    in_x = x; in_y = y; in_last = last; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic sel, input logic [1:0] idx, input logic [31:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_idx = idx; cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  // Scenario tasks
  task automatic test_reset();
    repeat (2) step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_zero_re !== 64'h0) begin errors++; $display("FAIL reset_zero_re: got %h expected 0", out_zero_re); end
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0b expected 0", commit_pending); end
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    // Get a beat stuck in the output and a commit pending, then reset mid-cycle.
    out_ready = 1'b0;
    send_beat(16'h1234, 16'h0000, 1'b0);
    checks++; if (out_zero_re[15:0] !== 16'h1234) begin errors++; $display("FAIL mid_beat_data: got %h expected 1234", out_zero_re[15:0]); end
    commit();
    checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL mid_pending: got %0b expected 1", commit_pending); end
    checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL mid_dbg_state: got %0b expected 1", dbg_state); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid: got %0b expected 0", out_valid); end
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL async_pending: got %0b expected 0", commit_pending); end
    checks++; if (out_zero_re !== 64'h0) begin errors++; $display("FAIL async_zero_re: got %h expected 0", out_zero_re); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %0b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %0b expected 0", out_valid); end
  endtask

  task automatic test_basic_commit();
    cfg_write(1'b0, 2'd0, 32'h0100_FF00);
    commit();
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL idle_commit_pending: got %0b expected 0", commit_pending); end
    send_beat(16'h0200, 16'h0000, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %0b expected 1", out_valid); end
    checks++; if (out_zero_re[15:0] !== 16'h0100) begin errors++; $display("FAIL basic_zero_re0: got %h expected 0100", out_zero_re[15:0]); end
    checks++; if (out_zero_im[15:0] !== 16'h0100) begin errors++; $display("FAIL basic_zero_im0: got %h expected 0100", out_zero_im[15:0]); end
    checks++; if (out_zero_re[31:16] !== 16'h0200) begin errors++; $display("FAIL basic_zero_re1: got %h expected 0200", out_zero_re[31:16]); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL basic_out_last: got %0b expected 1", out_last); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %0b expected 0", out_valid); end
    // A shadow write alone must not reach the datapath.
    cfg_write(1'b0, 2'd1, 32'h0005_0003);
    send_beat(16'h0200, 16'h0000, 1'b1);
    checks++; if (out_zero_re[31:16] !== 16'h0200) begin errors++; $display("FAIL shadow_only: got %h expected 0200", out_zero_re[31:16]); end
    commit();
    send_beat(16'h0200, 16'h0000, 1'b1);
    checks++; if (out_zero_re[31:16] !== 16'h01FB) begin errors++; $display("FAIL commit_zero_re1: got %h expected 01fb", out_zero_re[31:16]); end
    checks++; if (out_zero_im[31:16] !== 16'hFFFD) begin errors++; $display("FAIL commit_zero_im1: got %h expected fffd", out_zero_im[31:16]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_v;
    step();
    out_ready = 1'b0;
    exp_q.push_back({16'h0010, 16'h0020});
    send_beat(16'h0010, 16'h0020, 1'b1);
    in_x = 16'h0030; in_y = 16'h0040; in_last = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_pole_re[15:0] !== 16'h0010) begin errors++; $display("FAIL bp_hold_%0d: got %h expected 0010", c, out_pole_re[15:0]); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %0b expected 0", c, in_ready); end
      step();
    end
    exp_q.push_back({16'h0030, 16'h0040});
    out_ready = 1'b1;
    for (int c = 0; c < 8 && exp_q.size() != 0; c++) begin
      if (out_valid && out_ready) begin
        exp_v = exp_q.pop_front();
        checks++;
        if ({out_pole_re[15:0], out_pole_im[15:0]} !== exp_v) begin
          errors++; $display("FAIL bp_deliver: got %h expected %h", {out_pole_re[15:0], out_pole_im[15:0]}, exp_v);
        end
      end
      step();
      in_valid = 1'b0;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_timeout: got %0d outstanding expected 0", exp_q.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate: got out_valid %0b expected 0", out_valid); end
    exp_q.delete();
  endtask

  task automatic test_mid_frame_commit();
    cfg_write(1'b1, 2'd0, 32'h0010_0000);
    send_beat(16'h0101, 16'h0000, 1'b0);
    send_beat(16'h0102, 16'h0000, 1'b0);
    commit();
    checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL mf_pending_set: got %0b expected 1", commit_pending); end
    send_beat(16'h0103, 16'h0000, 1'b0);
    checks++; if (out_pole_re[15:0] !== 16'h0103) begin errors++; $display("FAIL mf_beat3: got %h expected 0103", out_pole_re[15:0]); end
    // Second commit is ignored; a shadow write in PEND still lands.
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_idx = 2'd1; cfg_data = 32'h0001_0000; cfg_commit = 1'b1;
    send_beat(16'h0104, 16'h0000, 1'b0);
    cfg_we = 1'b0; cfg_commit = 1'b0;
    checks++; if (out_pole_re[15:0] !== 16'h0104) begin errors++; $display("FAIL mf_beat4: got %h expected 0104", out_pole_re[15:0]); end
    checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL mf_pending_hold: got %0b expected 1", commit_pending); end
    send_beat(16'h0105, 16'h0000, 1'b1);
    checks++; if (out_pole_re[15:0] !== 16'h0105) begin errors++; $display("FAIL mf_beat5_old: got %h expected 0105", out_pole_re[15:0]); end
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL mf_pending_clear: got %0b expected 0", commit_pending); end
    send_beat(16'h0100, 16'h0000, 1'b1);
    checks++; if (out_pole_re[15:0] !== 16'h00F0) begin errors++; $display("FAIL mf_next_frame: got %h expected 00f0", out_pole_re[15:0]); end
    checks++; if (out_pole_re[31:16] !== 16'h00FF) begin errors++; $display("FAIL mf_pend_write: got %h expected 00ff", out_pole_re[31:16]); end
  endtask

  task automatic test_commit_with_beat();
    cfg_write(1'b1, 2'd3, 32'h0003_0000);
    cfg_commit = 1'b1;
    send_beat(16'h0100, 16'h0000, 1'b1);
    cfg_commit = 1'b0;
    checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL cb_pending: got %0b expected 1", commit_pending); end
    checks++; if (out_pole_re[63:48] !== 16'h0100) begin errors++; $display("FAIL cb_beat0: got %h expected 0100", out_pole_re[63:48]); end
    send_beat(16'h0100, 16'h0000, 1'b1);
    checks++; if (out_pole_re[63:48] !== 16'h0100) begin errors++; $display("FAIL cb_last_old: got %h expected 0100", out_pole_re[63:48]); end
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL cb_pending_clear: got %0b expected 0", commit_pending); end
    send_beat(16'h0100, 16'h0000, 1'b1);
    checks++; if (out_pole_re[63:48] !== 16'h00FD) begin errors++; $display("FAIL cb_new_roots: got %h expected 00fd", out_pole_re[63:48]); end
    // Write and commit on the same edge: the written value is what gets copied.
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_idx = 2'd2; cfg_data = 32'h0002_0000;
    commit();
    cfg_we = 1'b0;
    send_beat(16'h0100, 16'h0000, 1'b1);
    checks++; if (out_pole_re[47:32] !== 16'h00FE) begin errors++; $display("FAIL merge_write: got %h expected 00fe", out_pole_re[47:32]); end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_re0, exp_im1;
    logic        exp_sat;
`ifdef SATURATE_EN
    exp_re0 = 16'h7FFF; exp_im1 = 16'h8000; exp_sat = 1'b1;
`else
    exp_re0 = 16'hFFFF; exp_im1 = 16'h7FFF; exp_sat = 1'b0;
`endif
    cfg_write(1'b1, 2'd0, 32'h8000_0000);
    cfg_write(1'b1, 2'd1, 32'h0001_0001);
    commit();
    send_beat(16'h7FFF, 16'h8000, 1'b1);
    checks++; if (out_pole_re[15:0] !== exp_re0) begin errors++; $display("FAIL sat_pos_re: got %h expected %h", out_pole_re[15:0], exp_re0); end
    checks++; if (out_pole_im[31:16] !== exp_im1) begin errors++; $display("FAIL sat_neg_im: got %h expected %h", out_pole_im[31:16], exp_im1); end
    checks++; if (out_sat !== exp_sat) begin errors++; $display("FAIL sat_flag: got %0b expected %0b", out_sat, exp_sat); end
    send_beat(16'hFFFF, 16'h0001, 1'b1);
    checks++; if (out_pole_re[15:0] !== 16'h7FFF) begin errors++; $display("FAIL nosat_re: got %h expected 7fff", out_pole_re[15:0]); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL nosat_flag: got %0b expected 0", out_sat); end
  endtask

  task automatic test_out_of_range();
    cfg_write(1'b0, 2'd3, 32'h1234_5678);
    commit();
    send_beat(16'h0200, 16'h0000, 1'b1);
    checks++; if (out_zero_re3 !== {16'h0200, 16'h01FB, 16'h0100}) begin errors++; $display("FAIL oor_zero_re: got %h expected 020001fb0100", out_zero_re3); end
    checks++; if (out_zero_im3 !== {16'h0000, 16'hFFFD, 16'h0100}) begin errors++; $display("FAIL oor_zero_im: got %h expected 0000fffd0100", out_zero_im3); end
    checks++; if (out_valid3 !== 1'b1 || out_last3 !== 1'b1) begin errors++; $display("FAIL oor_valid_last: got %0b%0b expected 11", out_valid3, out_last3); end
    checks++; if (commit_pending3 !== 1'b0) begin errors++; $display("FAIL oor_pending: got %0b expected 0", commit_pending3); end
    checks++; if (out_zero_re[63:48] !== 16'hEFCC) begin errors++; $display("FAIL inrange_zero_re3: got %h expected efcc", out_zero_re[63:48]); end
    checks++; if (out_zero_im[63:48] !== 16'hA988) begin errors++; $display("FAIL inrange_zero_im3: got %h expected a988", out_zero_im[63:48]); end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_backpressure();
    test_mid_frame_commit();
    test_commit_with_beat();
    test_saturation();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
